// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared sizing and requester numbering for the writeback arbiter.
package regfile_wb_arbiter_pkg;
  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned NREQ = 3;

  localparam int unsigned REQ_ALU = 0;
  localparam int unsigned REQ_LSU = 1;
  localparam int unsigned REQ_MDU = 2;

  localparam int unsigned ZERO_REG = 0;
endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester after the last winner.
module rr_arbiter #(
  parameter int unsigned N  = 3,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);
  logic [IW-1:0] last;
  logic          found;
  int unsigned   idx;

  // Scan last+1 .. last+N (mod N) and grant the first active request.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = (32'(last) + k) % N;
      if (!found && req[IW'(idx)]) begin
        gnt[IW'(idx)] = 1'b1;
        gnt_idx       = IW'(idx);
        found         = 1'b1;
      end
    end
  end

  // Any active request is accepted, so the pointer moves whenever one exists.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= IW'(N - 1);
    end else if (|req) begin
      last <= gnt_idx;
    end
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: round-robin select, one-cycle write stage, pending-write scoreboard.
module regfile_wb_arbiter #(
  parameter int unsigned NREQ = regfile_wb_arbiter_pkg::NREQ,
  parameter int unsigned XLEN = regfile_wb_arbiter_pkg::XLEN,
  parameter int unsigned AW   = regfile_wb_arbiter_pkg::AW
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*XLEN-1:0] req_data,
  input  logic                 iss_valid,
  input  logic [AW-1:0]        iss_rd,
  output logic                 iss_ready,
  output logic [2**AW-1:0]     busy,
  output logic [AW-1:0]        wr_addr,
  output logic [XLEN-1:0]      wr_data,
  output logic                 RegWrite
);
  import regfile_wb_arbiter_pkg::*;

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IW-1:0]     gnt_idx;
  logic              xfer;
  logic [AW-1:0]     sel_addr;
  logic [XLEN-1:0]   sel_data;
  logic [2**AW-1:0]  busy_nxt;

  rr_arbiter #(.N(NREQ), .IW(IW)) u_arb (
    .clk     (clk),
    .rst_n   (reset),
    .req     (req_valid),
    .gnt     (req_ready),
    .gnt_idx (gnt_idx)
  );

  assign xfer      = |req_valid;
  assign iss_ready = ~busy[iss_rd];

  // Mux the winning requester's address and data.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (xfer && (IW'(i) == gnt_idx)) begin
        sel_addr = req_addr[i*AW +: AW];
        sel_data = req_data[i*XLEN +: XLEN];
      end
    end
  end

  // Write stage: register the winner; x0 updates addr/data but never enables the write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      RegWrite <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      RegWrite <= xfer && (sel_addr != AW'(ZERO_REG));
      if (xfer) begin
        wr_addr <= sel_addr;
        wr_data <= sel_data;
      end
    end
  end

  // Scoreboard next state: clear on writeback, then set on issue so a same-edge set wins.
  always_comb begin
    busy_nxt = busy;
    if (xfer && (sel_addr != AW'(ZERO_REG))) begin
      busy_nxt[sel_addr] = 1'b0;
    end
    if (iss_valid && iss_ready && (iss_rd != AW'(ZERO_REG))) begin
      busy_nxt[iss_rd] = 1'b1;
    end
    busy_nxt[ZERO_REG] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter.
module tb_regfile_wb_arbiter;
  localparam int unsigned NREQ = 3;
  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = 5;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*XLEN-1:0] req_data;
  logic                 iss_valid;
  logic [AW-1:0]        iss_rd;
  logic                 iss_ready;
  logic [2**AW-1:0]     busy;
  logic [AW-1:0]        wr_addr;
  logic [XLEN-1:0]      wr_data;
  logic                 RegWrite;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  regfile_wb_arbiter #(.NREQ(NREQ), .XLEN(XLEN), .AW(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .iss_ready (iss_ready),
    .busy      (busy),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .RegWrite  (RegWrite)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_g [6];
    exp_g = '{1, 2, 0, 1, 2, 0};

    reset = 1'b0;
    req_valid = '0; req_addr = '0; req_data = '0;
    iss_valid = 1'b0; iss_rd = '0;
    tick(); tick();
    chk("rst_regwrite", RegWrite, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_iss_ready", iss_ready, 1);
    reset = 1'b1;
    tick();

    // Single ALU writeback
    req_valid = 3'b001; req_addr[0*AW +: AW] = 5; req_data[0*XLEN +: XLEN] = 32'hDEADBEEF;
    #1 chk("alu_ready", req_ready, 3'b001);
    tick();
    req_valid = '0;
    chk("alu_regwrite", RegWrite, 1);
    chk("alu_wr_addr", wr_addr, 5);
    chk("alu_wr_data", wr_data, 32'hDEADBEEF);
    tick();
    chk("alu_idle_regwrite", RegWrite, 0);
    chk("alu_idle_hold", wr_addr, 5);

    // All three valid; pointer currently at ALU, so rotation starts at LSU
    req_addr  = {5'd3, 5'd2, 5'd1};
    req_data  = {32'h33, 32'h22, 32'h11};
    req_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      #1 chk("rr_ready", req_ready, 64'(1) << exp_g[k]);
      tick();
      if (k == 5) req_valid = '0;
      chk("rr_regwrite", RegWrite, 1);
      chk("rr_wr_addr", wr_addr, 64'(exp_g[k] + 1));
      chk("rr_wr_data", wr_data, 64'(32'h11 * (exp_g[k] + 1)));
    end
    tick();
    chk("rr_end_regwrite", RegWrite, 0);

    // LSU write to x0: accepted, no write enable, busy untouched
    req_valid = 3'b010; req_addr[1*AW +: AW] = 0; req_data[1*XLEN +: XLEN] = 32'h1234;
    #1 chk("x0_ready", req_ready, 3'b010);
    tick();
    req_valid = '0;
    chk("x0_regwrite", RegWrite, 0);
    chk("x0_wr_addr", wr_addr, 0);
    chk("x0_wr_data", wr_data, 32'h1234);
    chk("x0_busy", busy, 0);

    // Issue rd=7, WAW stall, MDU writeback clears, retry succeeds
    iss_valid = 1'b1; iss_rd = 7;
    #1 chk("iss7_ready", iss_ready, 1);
    tick();
    chk("iss7_busy", busy, 32'h0000_0080);
    chk("iss7_waw", iss_ready, 0);
    req_valid = 3'b100; req_addr[2*AW +: AW] = 7; req_data[2*XLEN +: XLEN] = 32'h77;
    #1 chk("mdu_ready", req_ready, 3'b100);
    tick();
    req_valid = '0;
    chk("mdu_regwrite", RegWrite, 1);
    chk("mdu_wr_addr", wr_addr, 7);
    chk("mdu_busy_clear", busy, 0);
    chk("retry_ready", iss_ready, 1);
    tick();
    iss_valid = 1'b0;
    chk("retry_busy", busy, 32'h0000_0080);

    // Same-edge issue and writeback to rd=9: set wins
    iss_valid = 1'b1; iss_rd = 9;
    req_valid = 3'b001; req_addr[0*AW +: AW] = 9; req_data[0*XLEN +: XLEN] = 32'h99;
    #1 chk("same_iss_ready", iss_ready, 1);
    chk("same_req_ready", req_ready, 3'b001);
    tick();
    iss_valid = 1'b0; req_valid = '0;
    chk("same_busy", busy, 32'h0000_0280);
    chk("same_regwrite", RegWrite, 1);
    chk("same_wr_addr", wr_addr, 9);

    // Issue rd=3 while LSU writes 5, then assert reset mid-cycle
    iss_valid = 1'b1; iss_rd = 3;
    req_valid = 3'b010; req_addr[1*AW +: AW] = 5; req_data[1*XLEN +: XLEN] = 32'h55;
    tick();
    iss_valid = 1'b0; req_valid = '0;
    chk("pre_rst_regwrite", RegWrite, 1);
    chk("pre_rst_busy", busy, 32'h0000_0288);
    #2 reset = 1'b0;
    #1 chk("async_regwrite", RegWrite, 0);
    chk("async_busy", busy, 0);
    chk("async_wr_addr", wr_addr, 0);
    chk("async_wr_data", wr_data, 0);
    tick();
    reset = 1'b1;

    // After reset, ALU wins first with all valid
    req_addr  = {5'd3, 5'd2, 5'd1};
    req_data  = {32'h33, 32'h22, 32'h11};
    req_valid = 3'b111;
    #1 chk("post_rst_ready", req_ready, 3'b001);
    tick();
    req_valid = '0;
    chk("post_rst_regwrite", RegWrite, 1);
    chk("post_rst_wr_addr", wr_addr, 1);
    chk("post_rst_wr_data", wr_data, 32'h11);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
